// File: rtl/contador_eventos.sv
// Event counter for the Mealy detector output z, with sticky wrap flag
// and a retriggerable stretcher that keeps a board LED visible.
module contador_eventos #(
  parameter int unsigned WIDTH   = 4,
  parameter int unsigned STRETCH = 12000000,
  parameter int unsigned EDGE    = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             z,
  input  logic             en,
  input  logic             clr,
  output logic [WIDTH-1:0] count,
  output logic             ovf,
  output logic             led
);

  localparam int unsigned TW = $clog2(STRETCH);
  localparam logic [TW-1:0] TLOAD = TW'(STRETCH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'b01,
    S_HOLD = 2'b10
  } state_t;

  logic             r_zq;
  logic [WIDTH-1:0] r_count;
  logic             r_ovf;
  logic             r_led;
  state_t           r_state;
  logic [TW-1:0]    r_timer;

  logic             w_ev;
  logic             w_acc;
  state_t           w_state_nxt;
  logic [TW-1:0]    w_timer_nxt;

  assign w_ev  = (EDGE == 0) ? z : (z & ~r_zq);
  assign w_acc = w_ev & en & ~clr;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_zq <= 1'b0;
    end else begin
      r_zq <= z;
    end
  end

  // clr wins over a coincident event
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count <= '0;
      r_ovf   <= 1'b0;
    end else if (clr) begin
      r_count <= '0;
      r_ovf   <= 1'b0;
    end else if (w_acc) begin
      r_count <= r_count + 1'b1;
      if (&r_count) begin
        r_ovf <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_timer <= '0;
      r_led   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_timer <= w_timer_nxt;
      r_led   <= (w_state_nxt == S_HOLD);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_timer_nxt = r_timer;
    case (r_state)
      S_IDLE: begin
        if (w_acc) begin
          w_state_nxt = S_HOLD;
          w_timer_nxt = TLOAD;
        end
      end
      S_HOLD: begin
        if (w_acc) begin
          w_timer_nxt = TLOAD;
        end else if (r_timer == '0) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_timer_nxt = r_timer - 1'b1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_timer_nxt = '0;
      end
    endcase
  end

  assign count = r_count;
  assign ovf   = r_ovf;
  assign led   = r_led;

endmodule

// File: tb/tb_contador_eventos.sv
// Directed bench for contador_eventos: level and edge variants side by
// side, checked every cycle against an event-history model.
module tb_contador_eventos;

  logic       clk;
  logic       reset;
  logic       z;
  logic       en;
  logic       clr;
  logic [3:0] cnt0;
  logic [3:0] cnt1;
  logic       ovf0;
  logic       ovf1;
  logic       led0;
  logic       led1;

  int checks;
  int errors;

  contador_eventos #(.WIDTH(4), .STRETCH(4), .EDGE(0)) u0 (
    .clk(clk), .reset(reset), .z(z), .en(en), .clr(clr),
    .count(cnt0), .ovf(ovf0), .led(led0)
  );

  contador_eventos #(.WIDTH(4), .STRETCH(4), .EDGE(1)) u1 (
    .clk(clk), .reset(reset), .z(z), .en(en), .clr(clr),
    .count(cnt1), .ovf(ovf1), .led(led1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t",
               name, act, exp, $time);
    end
  endtask

  // model: events since clear (mod 16), wrap seen, edge of last event
  int m_cnt [2];
  int m_ovf [2];
  int m_last[2];
  int m_n;
  bit m_zq;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int e = 0; e < 2; e++) begin
        m_cnt[e]  = 0;
        m_ovf[e]  = 0;
        m_last[e] = -100;
      end
      m_n  = 0;
      m_zq = 1'b0;
    end else begin
      m_n++;
      for (int e = 0; e < 2; e++) begin
        bit ev;
        ev = (e == 0) ? z : (z && !m_zq);
        if (clr) begin
          m_cnt[e] = 0;
          m_ovf[e] = 0;
        end else if (ev && en) begin
          m_cnt[e] = (m_cnt[e] + 1) % 16;
          if (m_cnt[e] == 0) m_ovf[e] = 1;
          m_last[e] = m_n;
        end
      end
      m_zq = z;
    end
  end

  always @(negedge clk) begin
    chk("cnt0", cnt0, m_cnt[0]);
    chk("ovf0", ovf0, m_ovf[0]);
    chk("led0", led0, int'((m_n - m_last[0]) < 4));
    chk("cnt1", cnt1, m_cnt[1]);
    chk("ovf1", ovf1, m_ovf[1]);
    chk("led1", led1, int'((m_n - m_last[1]) < 4));
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic pulse();
    z = 1'b1;
    tick();
    z = 1'b0;
    tick();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b0;
    z      = 1'b0;
    en     = 1'b0;
    clr    = 1'b0;
    repeat (2) tick();
    chk("rst_cnt", cnt0, 0);
    chk("rst_ovf", ovf0, 0);
    chk("rst_led", led0, 0);
    reset = 1'b1;
    tick();

    // level counting: z high for three edges
    en = 1'b1;
    z  = 1'b1;
    repeat (3) tick();
    chk("lvl_cnt0", cnt0, 3);
    chk("lvl_cnt1", cnt1, 1);
    chk("lvl_led0", led0, 1);
    z = 1'b0;
    repeat (3) tick();
    chk("lvl_led0_hold", led0, 1);
    tick();
    chk("lvl_led0_off", led0, 0);

    // edge counting: 3 high, 2 low, 1 high
    clr = 1'b1;
    tick();
    clr = 1'b0;
    z   = 1'b1;
    repeat (3) tick();
    z = 1'b0;
    repeat (2) tick();
    z = 1'b1;
    tick();
    z = 1'b0;
    chk("edge_cnt1", cnt1, 2);
    chk("edge_cnt0", cnt0, 4);
    repeat (5) tick();

    // wrap after 16 events, then clear beats a coincident event
    clr = 1'b1;
    tick();
    clr = 1'b0;
    repeat (16) pulse();
    chk("wrap_cnt0", cnt0, 0);
    chk("wrap_ovf0", ovf0, 1);
    chk("wrap_ovf1", ovf1, 1);
    repeat (3) tick();
    chk("ovf_sticky", ovf0, 1);
    clr = 1'b1;
    z   = 1'b1;
    tick();
    clr = 1'b0;
    z   = 1'b0;
    chk("clr_cnt0", cnt0, 0);
    chk("clr_ovf0", ovf0, 0);
    chk("clr_cnt1", cnt1, 0);
    repeat (6) tick();

    // enable gating, then one accepted event
    en = 1'b0;
    repeat (5) pulse();
    chk("gate_cnt0", cnt0, 0);
    chk("gate_led0", led0, 0);
    en = 1'b1;
    z  = 1'b1;
    tick();
    z = 1'b0;
    chk("en_cnt0", cnt0, 1);
    for (int i = 0; i < 3; i++) begin
      chk("en_led_on", led0, 1);
      tick();
    end
    chk("en_led_last", led0, 1);
    tick();
    chk("en_led_off", led0, 0);
    repeat (2) tick();

    // retrigger: events two cycles apart
    for (int i = 0; i < 4; i++) begin
      z = 1'b1;
      tick();
      z = 1'b0;
      chk("rt_led_a", led1, 1);
      tick();
      chk("rt_led_b", led1, 1);
    end
    repeat (2) tick();
    chk("rt_led_hold", led1, 1);
    tick();
    chk("rt_led_off", led1, 0);
    repeat (2) tick();

    // asynchronous reset mid-HOLD with count=5
    clr = 1'b1;
    tick();
    clr = 1'b0;
    repeat (5) pulse();
    chk("pre_rst_cnt", cnt0, 5);
    chk("pre_rst_led", led0, 1);
    reset = 1'b0;
    #1;
    chk("arst_cnt0", cnt0, 0);
    chk("arst_ovf0", ovf0, 0);
    chk("arst_led0", led0, 0);
    chk("arst_led1", led1, 0);
    tick();
    repeat (2) tick();

    // z already high on the first edge after release
    z = 1'b1;
    reset = 1'b1;
    tick();
    chk("post_cnt0", cnt0, 1);
    chk("post_cnt1", cnt1, 1);
    z = 1'b0;
    repeat (6) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
